// File: rtl/lut_accumulator.sv
// Windowed complex accumulator behind the +/- factor LUT bank, valid/ready on both sides.
// Define LUT_ACC_SAT_EN for a saturating output reduce plus sticky out_sat; default wraps.

package lut_acc_pkg;
   localparam int CW = 16;
   typedef struct packed {
      logic signed [CW-1:0] r;
      logic signed [CW-1:0] i;
   } cplx_t;
endpackage

// state | meaning
// FILL  | win_cnt < DEPTH-1, every offered sample is taken
// LAST  | win_cnt == DEPTH-1, next accept closes the window; stalls while previous sum unconsumed
module lut_accumulator
   import lut_acc_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int SHIFT = 0,
   localparam int CNT_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rstn,
   input  cplx_t            in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             clear,
   output cplx_t            out_data,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef LUT_ACC_SAT_EN
   output logic             out_sat,
`endif
   output logic [CNT_W-1:0] win_cnt
);

   localparam int ACC_W = CW + CNT_W;

   typedef enum logic {FILL, LAST} state_t;

   state_t                  state, state_nxt;
   logic signed [ACC_W-1:0] acc_r, acc_i;
   logic signed [ACC_W-1:0] sum_r, sum_i;
   logic signed [CW-1:0]    red_r, red_i;
   logic                    accept, wr_sum;

   assign in_ready = !(state == LAST && out_valid && !out_ready);
   assign accept   = in_valid & in_ready;
   assign wr_sum   = accept & (state == LAST) & ~clear;

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = FILL;
      end else if (accept) begin
         if (state == LAST)
            state_nxt = FILL;
         else if (win_cnt == CNT_W'(DEPTH-2))
            state_nxt = LAST;
      end
   end

   // Sign-extend into the wider accumulator so a full window can never overflow.
   always_comb begin
      sum_r = acc_r + {{CNT_W{in_data.r[CW-1]}}, in_data.r};
      sum_i = acc_i + {{CNT_W{in_data.i[CW-1]}}, in_data.i};
   end

`ifdef LUT_ACC_SAT_EN
   localparam logic signed [ACC_W-1:0] MAX_V = {{(CNT_W+1){1'b0}}, {(CW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

   logic signed [ACC_W-1:0] shr_r, shr_i;
   logic                    clip;

   function automatic logic signed [CW-1:0] sat(input logic signed [ACC_W-1:0] v);
      if (v > MAX_V)      return {1'b0, {(CW-1){1'b1}}};
      else if (v < MIN_V) return {1'b1, {(CW-1){1'b0}}};
      else                return v[CW-1:0];
   endfunction

   always_comb begin
      shr_r = sum_r >>> SHIFT;
      shr_i = sum_i >>> SHIFT;
      red_r = sat(shr_r);
      red_i = sat(shr_i);
      clip  = (shr_r > MAX_V) || (shr_r < MIN_V) || (shr_i > MAX_V) || (shr_i < MIN_V);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         out_sat <= 1'b0;
      else if (clear)
         out_sat <= 1'b0;
      else if (wr_sum && clip)
         out_sat <= 1'b1;
   end
`else
   always_comb begin
      red_r = CW'(sum_r >>> SHIFT);
      red_i = CW'(sum_i >>> SHIFT);
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= FILL;
         acc_r     <= '0;
         acc_i     <= '0;
         win_cnt   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clear) begin
            acc_r   <= '0;
            acc_i   <= '0;
            win_cnt <= '0;
         end else if (accept) begin
            if (state == LAST) begin
               acc_r   <= '0;
               acc_i   <= '0;
               win_cnt <= '0;
            end else begin
               acc_r   <= sum_r;
               acc_i   <= sum_i;
               win_cnt <= win_cnt + CNT_W'(1);
            end
         end
         // A fresh sum overrides a same-cycle consume so it is never lost.
         if (wr_sum) begin
            out_data.r <= red_r;
            out_data.i <= red_i;
            out_valid  <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lut_accumulator.sv
// Directed and randomized checks of lut_accumulator with DEPTH=4 (SHIFT=0 and SHIFT=2 instances).
module tb_lut_accumulator;
   import lut_acc_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       in_valid = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   cplx_t      in_data = '0;
   logic       in_ready, out_valid, in_ready_s2, out_valid_s2;
   cplx_t      out_data, out_data_s2;
   logic [1:0] win_cnt, win_cnt_s2;
`ifdef LUT_ACC_SAT_EN
   logic       out_sat, out_sat_s2;
`endif
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lut_accumulator #(.DEPTH(4), .SHIFT(0)) dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .clear(clear), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef LUT_ACC_SAT_EN
      .out_sat(out_sat),
`endif
      .win_cnt(win_cnt));

   lut_accumulator #(.DEPTH(4), .SHIFT(2)) dut_s2 (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s2),
      .clear(clear), .out_data(out_data_s2), .out_valid(out_valid_s2), .out_ready(out_ready),
`ifdef LUT_ACC_SAT_EN
      .out_sat(out_sat_s2),
`endif
      .win_cnt(win_cnt_s2));

   function automatic cplx_t mk(input int r, input int i);
      cplx_t c;
      c.r = 16'(r);
      c.i = 16'(i);
      return c;
   endfunction

   function automatic int red(input int s);
`ifdef LUT_ACC_SAT_EN
      if (s > 32767) return 32767;
      if (s < -32768) return -32768;
`endif
      return s;
   endfunction

   task automatic apply_reset();
      rstn = 1'b0;
      in_valid = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Offer one sample and hold it until accepted; returns at posedge+1 after the accept.
   task automatic push(input int r, input int i);
      bit ok = 1'b0;
      in_data = mk(r, i);
      in_valid = 1'b1;
      for (int k = 0; k < 100 && !ok; k++) begin
         #1;
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL push_timeout: sample (%0d,%0d) not accepted within 100 cycles", r, i);
      end
   endtask

   task automatic test_reset();
      out_ready = 1'b0;
      apply_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      n_checks++; if (win_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_win_cnt: got %0d want 0", win_cnt); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(1, -1);
         if (k < 3) begin
            n_checks++; if (win_cnt !== 2'(k+1)) begin n_fail++; $display("FAIL basic_win_cnt: got %0d want %0d", win_cnt, k+1); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0 after sample %0d", out_valid, k+1); end
         end
      end
      n_checks++; if (win_cnt !== 2'd0) begin n_fail++; $display("FAIL basic_wrap_cnt: got %0d want 0", win_cnt); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_checks++; if (out_data !== mk(4, -4)) begin n_fail++; $display("FAIL basic_sum: got (%0d,%0d) want (4,-4)", out_data.r, out_data.i); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push(3, 5);
      n_checks++; if (out_valid !== 1'b1 || out_data !== mk(12, 20)) begin n_fail++; $display("FAIL b2b_first: got v=%b (%0d,%0d) want v=1 (12,20)", out_valid, out_data.r, out_data.i); end
      for (int k = 0; k < 3; k++) push(-2, 7);
      n_checks++; if (win_cnt !== 2'd3) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 3", win_cnt); end
      in_data = mk(-2, 7);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall: got in_ready=%b want 0", in_ready); end
         @(posedge clk); #1;
      end
      n_checks++; if (win_cnt !== 2'd3 || out_data !== mk(12, 20)) begin n_fail++; $display("FAIL b2b_hold: got cnt=%0d (%0d,%0d) want cnt=3 (12,20)", win_cnt, out_data.r, out_data.i); end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release: got in_ready=%b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== mk(-8, 28)) begin n_fail++; $display("FAIL b2b_second: got v=%b (%0d,%0d) want v=1 (-8,28)", out_valid, out_data.r, out_data.i); end
      n_checks++; if (win_cnt !== 2'd0) begin n_fail++; $display("FAIL b2b_cnt_wrap: got %0d want 0", win_cnt); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      push(10, 10);
      push(10, 10);
      n_checks++; if (win_cnt !== 2'd2) begin n_fail++; $display("FAIL clr_pre_cnt: got %0d want 2", win_cnt); end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      n_checks++; if (win_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", win_cnt); end
      // sample offered together with clear must be dropped
      in_data = mk(100, 100);
      in_valid = 1'b1;
      clear = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      clear = 1'b0;
      n_checks++; if (win_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_accept_cnt: got %0d want 0", win_cnt); end
      for (int k = 0; k < 4; k++) push(1, 1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== mk(4, 4)) begin n_fail++; $display("FAIL clr_sum: got v=%b (%0d,%0d) want v=1 (4,4)", out_valid, out_data.r, out_data.i); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_single: got %b want 0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push(1, 2);
      for (int k = 0; k < 3; k++) push(5, 5);
      n_checks++; if (out_valid !== 1'b1 || win_cnt !== 2'd3) begin n_fail++; $display("FAIL ar_pre: got v=%b cnt=%0d want v=1 cnt=3", out_valid, win_cnt); end
      #2;
      rstn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || win_cnt !== 2'd0) begin n_fail++; $display("FAIL ar_clear: got v=%b data=%h cnt=%0d want all 0", out_valid, out_data, win_cnt); end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) push(2, 3);
      n_checks++; if (out_valid !== 1'b1 || out_data !== mk(8, 12)) begin n_fail++; $display("FAIL ar_sum: got v=%b (%0d,%0d) want v=1 (8,12)", out_valid, out_data.r, out_data.i); end
   endtask

   task automatic test_reduce();
      out_ready = 1'b1;
      apply_reset();
      for (int k = 0; k < 4; k++) push(32767, -32768);
      n_checks++; if (out_data_s2 !== mk(32767, -32768)) begin n_fail++; $display("FAIL red_shift2: got (%0d,%0d) want (32767,-32768)", out_data_s2.r, out_data_s2.i); end
`ifdef LUT_ACC_SAT_EN
      n_checks++; if (out_data !== mk(32767, -32768)) begin n_fail++; $display("FAIL red_sat: got (%0d,%0d) want (32767,-32768)", out_data.r, out_data.i); end
      n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL red_sat_flag: got %b want 1", out_sat); end
      n_checks++; if (out_sat_s2 !== 1'b0) begin n_fail++; $display("FAIL red_sat_flag_s2: got %b want 0", out_sat_s2); end
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL red_sat_clear: got %b want 0", out_sat); end
`else
      n_checks++; if (out_data !== mk(-4, 0)) begin n_fail++; $display("FAIL red_wrap: got (%0d,%0d) want (-4,0)", out_data.r, out_data.i); end
`endif
   endtask

   task automatic test_random();
      cplx_t q[$];
      int cr, ci, cnt, wins, cyc;
      logic exp_rdy;
      out_ready = 1'b0;
      apply_reset();
      cr = 0; ci = 0; cnt = 0; wins = 0; cyc = 0;
      while (wins < 1000 && cyc < 60000) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = cplx_t'($urandom());
         #1;
         exp_rdy = !(cnt == 3 && q.size() != 0 && !out_ready);
         n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready: got %b want %b cyc %0d", in_ready, exp_rdy, cyc); end
         n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid: got %b want %b cyc %0d", out_valid, q.size() != 0, cyc); end
         n_checks++; if (win_cnt !== 2'(cnt)) begin n_fail++; $display("FAIL rnd_win_cnt: got %0d want %0d cyc %0d", win_cnt, cnt, cyc); end
         n_checks++; if (in_ready_s2 !== exp_rdy || win_cnt_s2 !== 2'(cnt)) begin n_fail++; $display("FAIL rnd_s2_ctrl: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", in_ready_s2, win_cnt_s2, exp_rdy, cnt); end
         if (q.size() != 0 && out_ready) begin
            n_checks++; if (out_data !== q[0]) begin n_fail++; $display("FAIL rnd_sum: got (%0d,%0d) want (%0d,%0d) win %0d", out_data.r, out_data.i, q[0].r, q[0].i, wins); end
            void'(q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            cr += int'($signed(in_data.r));
            ci += int'($signed(in_data.i));
            cnt++;
            if (cnt == 4) begin
               q.push_back(mk(red(cr), red(ci)));
               cr = 0; ci = 0; cnt = 0;
               wins++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++; if (wins < 1000) begin n_fail++; $display("FAIL rnd_budget: got %0d windows want 1000", wins); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_reduce();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
